// File: rtl/fir_pkg.sv
// Shared types and width-derivation helpers for the symmetric TDM FIR filter.
package fir_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      MAC  = 1'b1
   } state_t;

   // Ceiling log2; returns 0 for values <= 1.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) result++;
      return result;
   endfunction

   // Channel tag width; a single channel still gets one bit.
   function automatic int ch_width(input int num_ch);
      return (num_ch > 1) ? clog2(num_ch) : 1;
   endfunction

   // Coefficient address width for the (n_taps+1)/2 unique coefficients.
   function automatic int ca_width(input int n_taps);
      return clog2((n_taps + 1) / 2);
   endfunction

   // Accumulator width: pre-added sample (data_w+1) times coefficient, summed over M terms.
   function automatic int acc_width(input int data_w, input int coeff_w, input int n_taps);
      return data_w + 1 + coeff_w + clog2((n_taps + 1) / 2);
   endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Combinational output stage: round half up, arithmetic right shift, clamp to OUT_W.
module fir_round_sat #(
   parameter int ACC_W = 38,
   parameter int OUT_W = 24
) (
   input  logic [ACC_W-1:0] acc,
   input  logic [5:0]       shift,
   output logic [OUT_W-1:0] data,
   output logic             sat
);

   // One guard bit so adding the rounding bias can never wrap.
   localparam int SUM_W = ACC_W + 1;
   localparam logic signed [SUM_W-1:0] ONE   = SUM_W'(1);
   localparam logic signed [SUM_W-1:0] MAX_V = {{(SUM_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [SUM_W-1:0] MIN_V = {{(SUM_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   logic signed [SUM_W-1:0] bias;
   logic signed [SUM_W-1:0] sum;
   logic signed [SUM_W-1:0] shifted;

   // Add half an output LSB, shift arithmetically, then clamp and flag.
   always_comb begin
      bias = '0;
      if (shift != 6'd0) begin
         bias = ONE << (shift - 6'd1);
      end
      sum     = {acc[ACC_W-1], acc} + bias;
      shifted = sum >>> shift;
      data    = shifted[OUT_W-1:0];
      sat     = 1'b0;
      if (shifted > MAX_V) begin
         data = MAX_V[OUT_W-1:0];
         sat  = 1'b1;
      end else if (shifted < MIN_V) begin
         data = MIN_V[OUT_W-1:0];
         sat  = 1'b1;
      end
   end

endmodule

// File: rtl/fir_symmetric_tdm.sv
// Multi-channel time-multiplexed odd-length symmetric FIR with run-time coefficients.
// One MAC per cycle folds a tap pair (x[k] + x[N-1-k]) onto the shared coefficient c[k].
module fir_symmetric_tdm
   import fir_pkg::*;
#(
   parameter int N_TAPS  = 51,
   parameter int DATA_W  = 16,
   parameter int COEFF_W = 16,
   parameter int NUM_CH  = 2,
   parameter int OUT_W   = 24
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [ch_width(NUM_CH)-1:0]    in_ch,
   input  logic [DATA_W-1:0]              in_data,
   input  logic                           coef_we,
   input  logic [ca_width(N_TAPS)-1:0]    coef_addr,
   input  logic [COEFF_W-1:0]             coef_data,
   input  logic [5:0]                     shift,
   output logic                           out_valid,
   output logic [ch_width(NUM_CH)-1:0]    out_ch,
   output logic [OUT_W-1:0]               out_data,
   output logic                           out_sat
);

   localparam int M      = (N_TAPS + 1) / 2;
   localparam int CH_W   = ch_width(NUM_CH);
   localparam int CA_W   = ca_width(N_TAPS);
   localparam int ACC_W  = acc_width(DATA_W, COEFF_W, N_TAPS);
   localparam int IDX_W  = clog2(N_TAPS);
   localparam int PROD_W = COEFF_W + DATA_W + 1;

   localparam logic [CA_W-1:0]  K_LAST   = CA_W'(M - 1);
   localparam logic [IDX_W-1:0] TAP_LAST = IDX_W'(N_TAPS - 1);

   state_t state_reg, state_next;

   logic signed [DATA_W-1:0]  dline_reg [NUM_CH][N_TAPS];
   logic signed [COEFF_W-1:0] coef_reg  [M];

   logic [CH_W-1:0]         ch_reg;
   logic [5:0]              shift_reg;
   logic [CA_W-1:0]         k_reg;
   logic signed [ACC_W-1:0] acc_reg;

   logic             out_valid_reg;
   logic [CH_W-1:0]  out_ch_reg;
   logic [OUT_W-1:0] out_data_reg;
   logic             out_sat_reg;

   logic ch_ok;
   logic accept;
   logic coef_wr;
   logic last_k;

   logic [IDX_W-1:0]           k_idx;
   logic [IDX_W-1:0]           mirror_idx;
   logic signed [DATA_W-1:0]   x_lo;
   logic signed [DATA_W-1:0]   x_hi;
   logic signed [DATA_W:0]     pre_add;
   logic signed [COEFF_W-1:0]  coef_sel;
   logic signed [PROD_W-1:0]   prod;
   logic signed [ACC_W-1:0]    acc_sum;

   logic [OUT_W-1:0] rs_data;
   logic             rs_sat;

   // Handshake qualification; out-of-range channels are silently dropped.
   assign ch_ok    = ({1'b0, in_ch} < (CH_W + 1)'(NUM_CH));
   assign in_ready = (state_reg == IDLE);
   assign accept   = in_valid && in_ready && ch_ok;
   assign coef_wr  = coef_we && in_ready && ({1'b0, coef_addr} < (CA_W + 1)'(M));
   assign last_k   = (k_reg == K_LAST);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next state: one MAC pass of M cycles per accepted sample.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (accept) state_next = MAC;
         MAC:     if (last_k) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Per-channel delay lines; only the addressed channel shifts on accept.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int c = 0; c < NUM_CH; c++) begin
            for (int t = 0; t < N_TAPS; t++) begin
               dline_reg[c][t] <= '0;
            end
         end
      end else if (accept) begin
         dline_reg[in_ch][0] <= in_data;
         for (int t = 1; t < N_TAPS; t++) begin
            dline_reg[in_ch][t] <= dline_reg[in_ch][t-1];
         end
      end
   end

   // Coefficient store; writes land before the MAC that starts with the same accept.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < M; k++) begin
            coef_reg[k] <= '0;
         end
      end else if (coef_wr) begin
         coef_reg[coef_addr] <= coef_data;
      end
   end

   // Tap-pair fetch and pre-add; the centre tap has no partner.
   always_comb begin
      k_idx      = IDX_W'(k_reg);
      mirror_idx = TAP_LAST - k_idx;
      x_lo       = dline_reg[ch_reg][k_idx];
      x_hi       = dline_reg[ch_reg][mirror_idx];
      coef_sel   = coef_reg[k_reg];
      if (last_k) begin
         pre_add = {x_lo[DATA_W-1], x_lo};
      end else begin
         pre_add = {x_lo[DATA_W-1], x_lo} + {x_hi[DATA_W-1], x_hi};
      end
      prod    = coef_sel * pre_add;
      acc_sum = acc_reg + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
   end

   // The output stage sees the accumulator including the final product so the
   // result registers on the same edge the FSM returns to IDLE.
   fir_round_sat #(
      .ACC_W(ACC_W),
      .OUT_W(OUT_W)
   ) u_round_sat (
      .acc   (acc_sum),
      .shift (shift_reg),
      .data  (rs_data),
      .sat   (rs_sat)
   );

   // Accept latching, accumulation and the registered result.
   always_ff @(posedge clk) begin
      if (rst) begin
         ch_reg        <= '0;
         shift_reg     <= '0;
         k_reg         <= '0;
         acc_reg       <= '0;
         out_valid_reg <= 1'b0;
         out_ch_reg    <= '0;
         out_data_reg  <= '0;
         out_sat_reg   <= 1'b0;
      end else begin
         out_valid_reg <= 1'b0;
         if (accept) begin
            ch_reg    <= in_ch;
            shift_reg <= shift;
            k_reg     <= '0;
            acc_reg   <= '0;
         end else if (state_reg == MAC) begin
            acc_reg <= acc_sum;
            k_reg   <= k_reg + CA_W'(1);
            if (last_k) begin
               out_valid_reg <= 1'b1;
               out_ch_reg    <= ch_reg;
               out_data_reg  <= rs_data;
               out_sat_reg   <= rs_sat;
            end
         end
      end
   end

   assign out_valid = out_valid_reg;
   assign out_ch    = out_ch_reg;
   assign out_data  = out_data_reg;
   assign out_sat   = out_sat_reg;

endmodule

// File: tb/tb_fir_symmetric_tdm.sv
// Randomised self-checking bench for fir_symmetric_tdm against a direct-convolution model.
module tb_fir_symmetric_tdm;

   localparam int N_TAPS  = 51;
   localparam int DATA_W  = 16;
   localparam int COEFF_W = 16;
   localparam int NUM_CH  = 2;
   localparam int OUT_W   = 24;
   localparam int M       = (N_TAPS + 1) / 2;
   localparam int ACC_W   = DATA_W + 1 + COEFF_W + 5;
   localparam longint OUT_MAX = (longint'(1) <<< (OUT_W - 1)) - 1;
   localparam longint OUT_MIN = -(longint'(1) <<< (OUT_W - 1));

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [0:0]        in_ch = '0;
   logic [DATA_W-1:0] in_data = '0;
   logic              coef_we = 1'b0;
   logic [4:0]        coef_addr = '0;
   logic [COEFF_W-1:0] coef_data = '0;
   logic [5:0]        shift = '0;
   logic              out_valid;
   logic [0:0]        out_ch;
   logic [OUT_W-1:0]  out_data;
   logic              out_sat;

   fir_symmetric_tdm #(
      .N_TAPS (N_TAPS),
      .DATA_W (DATA_W),
      .COEFF_W(COEFF_W),
      .NUM_CH (NUM_CH),
      .OUT_W  (OUT_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_ch    (in_ch),
      .in_data  (in_data),
      .coef_we  (coef_we),
      .coef_addr(coef_addr),
      .coef_data(coef_data),
      .shift    (shift),
      .out_valid(out_valid),
      .out_ch   (out_ch),
      .out_data (out_data),
      .out_sat  (out_sat)
   );

   always #5 clk = ~clk;

   int tests_run    = 0;
   int tests_failed = 0;

   // Reference state: history per channel (index 0 = newest) and unique coefficients.
   longint hist   [NUM_CH][N_TAPS];
   longint coef_m [M];

   task automatic check(input string tag, input longint got, input longint exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   function automatic int rnd16();
      return int'($urandom_range(0, 65535)) - 32768;
   endfunction

   function automatic void model_clear();
      for (int c = 0; c < NUM_CH; c++)
         for (int i = 0; i < N_TAPS; i++) hist[c][i] = 0;
      for (int k = 0; k < M; k++) coef_m[k] = 0;
   endfunction

   function automatic void model_push(input int ch, input int data);
      for (int i = N_TAPS - 1; i > 0; i--) hist[ch][i] = hist[ch][i-1];
      hist[ch][0] = data;
   endfunction

   // Full-length convolution with h[i] = c[min(i, N-1-i)], then round, shift, clamp.
   function automatic longint model_eval(input int ch, input int shft, output bit sat);
      longint acc;
      int     k;
      acc = 0;
      for (int i = 0; i < N_TAPS; i++) begin
         k = (i < M) ? i : (N_TAPS - 1 - i);
         acc += coef_m[k] * hist[ch][i];
      end
      if (shft > 0) acc += longint'(1) <<< (shft - 1);
      acc = acc >>> shft;
      sat = 1'b0;
      if (acc > OUT_MAX) begin acc = OUT_MAX; sat = 1'b1; end
      if (acc < OUT_MIN) begin acc = OUT_MIN; sat = 1'b1; end
      return acc;
   endfunction

   function automatic longint out_s();
      return longint'($signed(out_data));
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_clear();
   endtask

   task automatic load_coef(input int addr, input int val);
      coef_we = 1'b1; coef_addr = addr[4:0]; coef_data = val[COEFF_W-1:0];
      @(negedge clk);
      coef_we = 1'b0;
      coef_m[addr] = val;
   endtask

   // One transaction: called and returns on a falling edge with the block idle.
   task automatic send(input int ch, input int data, input int shft,
                       input bit wr, input int wr_addr, input int wr_val,
                       input bit busy_wr, output longint got);
      int     cyc;
      int     busy_cnt;
      longint exp_v;
      bit     exp_s;
      check("ready_before_accept", longint'(in_ready), 1);
      in_valid = 1'b1; in_ch = ch[0:0]; in_data = data[DATA_W-1:0]; shift = shft[5:0];
      if (wr) begin
         coef_we = 1'b1; coef_addr = wr_addr[4:0]; coef_data = wr_val[COEFF_W-1:0];
      end
      @(negedge clk);
      in_valid = 1'b0; coef_we = 1'b0;
      if (wr) coef_m[wr_addr] = wr_val;
      model_push(ch, data);
      exp_v = model_eval(ch, shft, exp_s);
      cyc = 1; busy_cnt = 0;
      while (!out_valid && cyc < M + 6) begin
         if (!in_ready) busy_cnt++;
         if (busy_wr && cyc == 5) begin
            coef_we = 1'b1;
            coef_addr = 5'($urandom_range(0, M - 1));
            coef_data = 16'($urandom_range(1, 65535));
         end else begin
            coef_we = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      coef_we = 1'b0;
      got = out_s();
      check("latency", cyc, M + 1);
      check("busy_cycles", busy_cnt, M);
      check("ready_with_result", longint'(in_ready), 1);
      check("out_data", got, exp_v);
      check("out_sat", longint'(out_sat), longint'(exp_s));
      check("out_ch", longint'(out_ch), ch);
      $display("[TB] tx ch=%0d in=%0d shift=%0d wr=%0d busy_wr=%0d -> out=%0d sat=%0d (exp %0d sat %0d)",
               ch, data, shft, wr, busy_wr, got, out_sat, exp_v, exp_s);
   endtask

   // Impulse of amplitude amp on one channel; c[k]=k+1 gives a triangular response.
   task automatic impulse_run(input int ch, input int amp);
      longint got;
      for (int j = 0; j < N_TAPS; j++) begin
         send(ch, (j == 0) ? amp : 0, 0, 1'b0, 0, 0, 1'b0, got);
         check("impulse_shape", got, longint'(amp) * ((j < M) ? (j + 1) : (N_TAPS - j)));
      end
   endtask

   initial begin
      longint got;
      int     acc_cnt;
      int     last_cy;
      int     ov_cnt;
      longint exp_v;
      bit     exp_s;

      model_clear();
      do_reset();
      check("rst_in_ready", longint'(in_ready), 1);
      check("rst_out_valid", longint'(out_valid), 0);
      check("rst_out_ch", longint'(out_ch), 0);
      check("rst_out_data", out_s(), 0);
      check("rst_out_sat", longint'(out_sat), 0);

      // Impulse response.
      for (int k = 0; k < M; k++) load_coef(k, k + 1);
      impulse_run(0, 1);

      // Channel isolation: ch0 zeros interleaved with a ch1 impulse of 100.
      for (int j = 0; j < N_TAPS; j++) begin
         send(0, 0, 0, 1'b0, 0, 0, 1'b0, got);
         check("iso_ch0_zero", got, 0);
         send(1, (j == 0) ? 100 : 0, 0, 1'b0, 0, 0, 1'b0, got);
         check("iso_ch1", got, 100 * ((j < M) ? (j + 1) : (N_TAPS - j)));
      end

      // Random coefficients, data, channels and shifts; includes same-cycle and busy writes.
      for (int k = 0; k < M; k++) load_coef(k, rnd16());
      for (int n = 0; n < 60; n++) begin
         send($urandom_range(0, NUM_CH - 1), rnd16(), $urandom_range(0, ACC_W - 1),
              ($urandom_range(0, 3) == 0), $urandom_range(0, M - 1), rnd16(),
              $urandom_range(0, 1), got);
      end

      // Positive and negative saturation.
      for (int k = 0; k < M; k++) load_coef(k, 32767);
      for (int j = 0; j < N_TAPS; j++) send(0, 32767, 0, 1'b0, 0, 0, 1'b0, got);
      check("sat_pos_data", got, 8388607);
      check("sat_pos_flag", longint'(out_sat), 1);
      for (int j = 0; j < N_TAPS; j++) send(0, -32768, 0, 1'b0, 0, 0, 1'b0, got);
      check("sat_neg_data", got, -8388608);
      check("sat_neg_flag", longint'(out_sat), 1);

      // Rounding through the centre tap only.
      for (int k = 0; k < M; k++) load_coef(k, (k == M - 1) ? 1 : 0);
      for (int j = 0; j < 3 + M - 1; j++) begin
         send(1, (j == 0) ? 3 : (j == 1) ? -3 : (j == 2) ? 2 : 0, 1, 1'b0, 0, 0, 1'b0, got);
         if (j == M - 1) check("round_3", got, 2);
         if (j == M)     check("round_m3", got, -1);
         if (j == M + 1) begin
            check("round_2", got, 1);
            check("round_nosat", longint'(out_sat), 0);
         end
      end

      // in_valid held high: one accept per M+1 cycles.
      in_valid = 1'b1; in_ch = 1'b0; in_data = '0; shift = '0;
      acc_cnt = 0; last_cy = 0;
      for (int cy = 0; cy < 4 * (M + 1) && acc_cnt < 3; cy++) begin
         if (in_ready) begin
            if (acc_cnt > 0) check("hold_gap", cy - last_cy, M + 1);
            last_cy = cy;
            acc_cnt++;
            model_push(0, 0);
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      check("hold_accepts", acc_cnt, 3);
      for (int cy = 0; cy < M + 4 && !out_valid; cy++) @(negedge clk);
      exp_v = model_eval(0, 0, exp_s);
      check("hold_out_valid", longint'(out_valid), 1);
      check("hold_out_data", out_s(), exp_v);

      // Reset in the middle of a MAC pass, with in_valid asserted alongside it.
      @(negedge clk);
      in_valid = 1'b1; in_ch = 1'b0; in_data = 16'd12345; shift = '0;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (9) @(negedge clk);
      rst = 1'b1; in_valid = 1'b1; in_data = 16'd7777;
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b0;
      model_clear();
      check("midrst_in_ready", longint'(in_ready), 1);
      check("midrst_out_valid", longint'(out_valid), 0);
      check("midrst_out_data", out_s(), 0);
      ov_cnt = 0;
      for (int cy = 0; cy < M + 3; cy++) begin
         if (out_valid) ov_cnt++;
         @(negedge clk);
      end
      check("midrst_no_result", ov_cnt, 0);
      for (int k = 0; k < M; k++) load_coef(k, k + 1);
      impulse_run(0, 1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
